// File: rtl/neq_cmp_stream_if.sv
// Handshake and data bundle for the neq_cmp_stream comparator stage.
// The master side produces operand pairs and consumes results; the slave side is the stage.
interface neq_cmp_stream_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   // Operand side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [2:0]       op;
   logic             is_signed;
   logic             clear;

   // Result side
   logic             out_valid;
   logic             out_ready;
   logic             result;
   logic             x_neq_y;

   // Debug / controller status
   logic [CNT_W-1:0] mismatch_cnt;
   logic             first_valid;
   logic [WIDTH-1:0] first_x;
   logic [WIDTH-1:0] first_y;

   modport master (
      output in_valid, X, Y, op, is_signed, clear, out_ready,
      input  in_ready, out_valid, result, x_neq_y,
             mismatch_cnt, first_valid, first_x, first_y
   );

   modport slave (
      input  in_valid, X, Y, op, is_signed, clear, out_ready,
      output in_ready, out_valid, result, x_neq_y,
             mismatch_cnt, first_valid, first_x, first_y
   );
endinterface

// File: rtl/neq_cmp_stream.sv
// Registered comparator stage: evaluates X op Y (signed or unsigned) behind a
// one-entry valid/ready output register, always reporting X != Y alongside.
// Also keeps a saturating mismatch counter and the first mismatching pair.
module neq_cmp_stream #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   neq_cmp_stream_if.slave   bus
);

   typedef enum logic [2:0] {
      OP_EQ  = 3'd0,
      OP_NEQ = 3'd1,
      OP_LT  = 3'd2,
      OP_LE  = 3'd3,
      OP_GT  = 3'd4,
      OP_GE  = 3'd5
   } cmp_op_e;

   // Result register and status state
   logic             out_valid_q,   out_valid_d;
   logic             result_q,      result_d;
   logic             x_neq_y_q,     x_neq_y_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic             first_valid_q, first_valid_d;
   logic [WIDTH-1:0] first_x_q,     first_x_d;
   logic [WIDTH-1:0] first_y_q,     first_y_d;

   // Combinational helpers
   logic             in_ready;
   logic             accept;
   logic             rel_eq;
   logic             rel_lt;
   logic             rel_result;

   // The only combinational output path: out_ready -> in_ready
   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   // Evaluate the selected relation for the pair currently presented
   always_comb begin
      rel_eq     = (bus.X == bus.Y);
      rel_lt     = bus.is_signed ? ($signed(bus.X) < $signed(bus.Y))
                                 : (bus.X < bus.Y);
      rel_result = 1'b0;
      case (cmp_op_e'(bus.op))
         OP_EQ:   rel_result = rel_eq;
         OP_NEQ:  rel_result = !rel_eq;
         OP_LT:   rel_result = rel_lt;
         OP_LE:   rel_result = rel_lt || rel_eq;
         OP_GT:   rel_result = !rel_lt && !rel_eq;
         OP_GE:   rel_result = !rel_lt;
         default: rel_result = 1'b0;
      endcase
   end

   // Next-state for the output register, counter and first-mismatch capture
   always_comb begin
      out_valid_d   = out_valid_q;
      result_d      = result_q;
      x_neq_y_d     = x_neq_y_q;
      cnt_d         = cnt_q;
      first_valid_d = first_valid_q;
      first_x_d     = first_x_q;
      first_y_d     = first_y_q;

      if (accept) begin
         out_valid_d = 1'b1;
         result_d    = rel_result;
         x_neq_y_d   = !rel_eq;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      // clear takes priority over a coincident accepted mismatch
      if (bus.clear) begin
         cnt_d         = '0;
         first_valid_d = 1'b0;
         first_x_d     = '0;
         first_y_d     = '0;
      end else if (accept && !rel_eq) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_x_d     = bus.X;
            first_y_d     = bus.Y;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         result_q      <= 1'b0;
         x_neq_y_q     <= 1'b0;
         cnt_q         <= '0;
         first_valid_q <= 1'b0;
         first_x_q     <= '0;
         first_y_q     <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         result_q      <= result_d;
         x_neq_y_q     <= x_neq_y_d;
         cnt_q         <= cnt_d;
         first_valid_q <= first_valid_d;
         first_x_q     <= first_x_d;
         first_y_q     <= first_y_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.result       = result_q;
   assign bus.x_neq_y      = x_neq_y_q;
   assign bus.mismatch_cnt = cnt_q;
   assign bus.first_valid  = first_valid_q;
   assign bus.first_x      = first_x_q;
   assign bus.first_y      = first_y_q;

endmodule

// File: tb/tb_neq_cmp_stream.sv
// Self-checking bench for neq_cmp_stream: directed scenarios plus a randomized
// run scored against a queue-based behavioural model.
module tb_neq_cmp_stream;

   localparam int unsigned W = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   neq_cmp_stream_if #(.WIDTH(W), .CNT_W(8)) bus  ();
   neq_cmp_stream_if #(.WIDTH(W), .CNT_W(2)) sbus ();

   neq_cmp_stream #(.WIDTH(W), .CNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   neq_cmp_stream #(.WIDTH(W), .CNT_W(2)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Relation evaluated on integers; signed operands reinterpreted by value.
   function automatic bit ref_rel(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [2:0] o, input logic sg);
      int a;
      int b;
      a = int'(x);
      b = int'(y);
      if (sg) begin
         if (a >= (1 << (W - 1))) a = a - (1 << W);
         if (b >= (1 << (W - 1))) b = b - (1 << W);
      end
      case (o)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return a <  b;
         3'd3:    return a <= b;
         3'd4:    return a >  b;
         3'd5:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] o, input logic sg, input logic clr, input logic rdy);
      bus.in_valid  = v;
      bus.X         = x;
      bus.Y         = y;
      bus.op        = o;
      bus.is_signed = sg;
      bus.clear     = clr;
      bus.out_ready = rdy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
      sbus.in_valid = 1'b0; sbus.X = '0; sbus.Y = '0; sbus.op = 3'd0;
      sbus.is_signed = 1'b0; sbus.clear = 1'b0; sbus.out_ready = 1'b1;
      #12;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.result !== 1'b0 || bus.x_neq_y !== 1'b0) begin failures++; $display("FAIL reset_result got=%b/%b exp=0/0", bus.result, bus.x_neq_y); end
      checks++;
      if (bus.mismatch_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.mismatch_cnt); end
      checks++;
      if (bus.first_valid !== 1'b0 || bus.first_x !== 4'd0 || bus.first_y !== 4'd0) begin
         failures++; $display("FAIL reset_first got=%b %h %h exp=0 0 0", bus.first_valid, bus.first_x, bus.first_y);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      drive(1'b1, 4'd3, 4'd9, 3'd2, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 1'b1 || bus.x_neq_y !== 1'b1) begin
         failures++; $display("FAIL basic_out got=%b%b%b exp=111", bus.out_valid, bus.result, bus.x_neq_y);
      end
      checks++;
      if (bus.mismatch_cnt !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", bus.mismatch_cnt); end
      checks++;
      if (bus.first_valid !== 1'b1 || bus.first_x !== 4'd3 || bus.first_y !== 4'd9) begin
         failures++; $display("FAIL basic_first got=%b %0d %0d exp=1 3 9", bus.first_valid, bus.first_x, bus.first_y);
      end
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_signed();
      drive(1'b1, 4'b1000, 4'b0001, 3'd4, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.result !== 1'b1 || bus.x_neq_y !== 1'b1) begin
         failures++; $display("FAIL unsigned_gt got=%b/%b exp=1/1", bus.result, bus.x_neq_y);
      end
      drive(1'b1, 4'b1000, 4'b0001, 3'd4, 1'b1, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.result !== 1'b0 || bus.x_neq_y !== 1'b1) begin
         failures++; $display("FAIL signed_gt got=%b/%b exp=0/1", bus.result, bus.x_neq_y);
      end
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_backpressure();
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 4'd5, 4'd5, 3'd1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 1'b0 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL bp_first got=v%b r%b rdy%b exp=v1 r0 rdy0", bus.out_valid, bus.result, bus.in_ready);
      end
      drive(1'b1, 4'd2, 4'd7, 3'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== 1'b0 || bus.x_neq_y !== 1'b0) begin
            failures++; $display("FAIL bp_hold got=%b%b%b exp=100", bus.out_valid, bus.result, bus.x_neq_y);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_comb got=%b exp=1", bus.in_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 1'b1 || bus.x_neq_y !== 1'b1) begin
         failures++; $display("FAIL bp_release got=%b%b%b exp=111", bus.out_valid, bus.result, bus.x_neq_y);
      end
      bus.in_valid = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.mismatch_cnt !== 8'd1 || bus.first_x !== 4'd2 || bus.first_y !== 4'd7) begin
         failures++; $display("FAIL bp_count got=%0d %0d %0d exp=1 2 7", bus.mismatch_cnt, bus.first_x, bus.first_y);
      end
   endtask

   task automatic test_saturation();
      logic [W-1:0] x;
      logic [W-1:0] y;
      int           exp_cnt;
      sbus.in_valid = 1'b1; sbus.out_ready = 1'b1; sbus.op = 3'd1; sbus.clear = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            x = 4'd1; y = 4'd2;
         end else begin
            x = W'($urandom_range(0, 15));
            y = x ^ W'($urandom_range(1, 15));
         end
         sbus.X = x; sbus.Y = y;
         tick();
         exp_cnt = (i + 1 > 3) ? 3 : i + 1;
         checks++;
         if (int'(sbus.mismatch_cnt) != exp_cnt) begin
            failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, sbus.mismatch_cnt, exp_cnt);
         end
         checks++;
         if (sbus.first_valid !== 1'b1 || sbus.first_x !== 4'd1 || sbus.first_y !== 4'd2) begin
            failures++; $display("FAIL sat_first[%0d] got=%b %0d %0d exp=1 1 2", i, sbus.first_valid, sbus.first_x, sbus.first_y);
         end
      end
      sbus.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_clear_collision();
      drive(1'b1, 4'd1, 4'd2, 3'd0, 1'b0, 1'b1, 1'b1);
      tick();
      checks++;
      if (bus.mismatch_cnt !== 8'd0 || bus.first_valid !== 1'b0) begin
         failures++; $display("FAIL clr_status got=%0d %b exp=0 0", bus.mismatch_cnt, bus.first_valid);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.x_neq_y !== 1'b1 || bus.result !== 1'b0) begin
         failures++; $display("FAIL clr_result got=%b%b%b exp=110", bus.out_valid, bus.x_neq_y, bus.result);
      end
      drive(1'b1, 4'd6, 4'd4, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.mismatch_cnt !== 8'd1 || bus.first_valid !== 1'b1 || bus.first_x !== 4'd6 || bus.first_y !== 4'd4) begin
         failures++; $display("FAIL clr_next got=%0d %b %0d %0d exp=1 1 6 4", bus.mismatch_cnt, bus.first_valid, bus.first_x, bus.first_y);
      end
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'd3, 4'd5, 3'd2, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=1", bus.out_valid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== 1'b0 || bus.x_neq_y !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL rmid_out got=v%b r%b n%b rdy%b exp=v0 r0 n0 rdy1", bus.out_valid, bus.result, bus.x_neq_y, bus.in_ready);
      end
      checks++;
      if (bus.mismatch_cnt !== 8'd0 || bus.first_valid !== 1'b0 || bus.first_x !== 4'd0 || bus.first_y !== 4'd0) begin
         failures++; $display("FAIL rmid_status got=%0d %b %0d %0d exp=0 0 0 0", bus.mismatch_cnt, bus.first_valid, bus.first_x, bus.first_y);
      end
      #1;
      rst_n = 1'b1;
      drive(1'b1, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 1'b1 || bus.mismatch_cnt !== 8'd0) begin
         failures++; $display("FAIL rmid_after got=v%b r%b c%0d exp=v1 r1 c0", bus.out_valid, bus.result, bus.mismatch_cnt);
      end
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      typedef struct packed { logic res; logic neq; } txn_t;
      txn_t         q[$];
      int           m_cnt;
      logic         m_fv;
      logic [W-1:0] m_fx;
      logic [W-1:0] m_fy;
      logic         v, rdy, sg, clr, acc;
      logic [W-1:0] x, y;
      logic [2:0]   o;
      txn_t         t;

      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1);
      tick();
      tick();
      m_cnt = 0; m_fv = 1'b0; m_fx = '0; m_fy = '0;

      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         x   = W'($urandom_range(0, 15));
         y   = ($urandom_range(0, 3) == 0) ? x : W'($urandom_range(0, 15));
         o   = 3'($urandom_range(0, 7));
         sg  = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 19) == 0);
         drive(v, x, y, o, sg, clr, rdy);
         #1;
         acc = v && (q.size() == 0 || rdy);
         checks++;
         if (bus.in_ready !== (q.size() == 0 || rdy)) begin
            failures++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, (q.size() == 0 || rdy));
         end
         tick();
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (acc) begin
            t.res = ref_rel(x, y, o, sg);
            t.neq = (x != y);
            q.push_back(t);
         end
         if (clr) begin
            m_cnt = 0; m_fv = 1'b0; m_fx = '0; m_fy = '0;
         end else if (acc && x != y) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_fv) begin
               m_fv = 1'b1; m_fx = x; m_fy = y;
            end
         end
         checks++;
         if (bus.out_valid !== (q.size() != 0)) begin
            failures++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", i, bus.out_valid, (q.size() != 0));
         end
         if (q.size() != 0) begin
            checks++;
            if (bus.result !== q[0].res || bus.x_neq_y !== q[0].neq) begin
               failures++; $display("FAIL rnd_result[%0d] got=%b/%b exp=%b/%b", i, bus.result, bus.x_neq_y, q[0].res, q[0].neq);
            end
         end
         checks++;
         if (int'(bus.mismatch_cnt) != m_cnt || bus.first_valid !== m_fv || bus.first_x !== m_fx || bus.first_y !== m_fy) begin
            failures++; $display("FAIL rnd_status[%0d] got=%0d %b %0d %0d exp=%0d %b %0d %0d", i,
                                 bus.mismatch_cnt, bus.first_valid, bus.first_x, bus.first_y, m_cnt, m_fv, m_fx, m_fy);
         end
      end
      drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_signed();
      test_backpressure();
      test_saturation();
      test_clear_collision();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
